// File: rtl/mul_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_operand_ctrl
// Purpose  : Sequential front/back end for a combinational N-bit array
//            multiplier. Two push-buttons are synchronized and debounced; a
//            load press captures operand A and then operand B from the
//            switches. The multiplier's truncated product and overflow flag
//            are then captured into a result register for display. A
//            saturating counter tracks how many operations overflowed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1          system clock, rising edge
//   rst        in   1          asynchronous active-low reset
//   sw         in   N          operand switches
//   btn_load   in   1          raw load button (bouncing, asynchronous)
//   btn_clear  in   1          raw clear button (bouncing, asynchronous)
//   op_a       out  N          operand A to multiplier
//   op_b       out  N          operand B to multiplier
//   prod       in   N          multiplier product (low N bits)
//   ovf        in   1          multiplier overflow flag
//   result     out  N          captured product
//   result_ovf out  1          captured overflow flag
//   done       out  1          a valid result is held
//   state      out  2          00 S_A, 01 S_B, 10 S_EXEC, 11 S_SHOW
//   ovf_count  out  OVF_CNT_W  saturating count of overflowed operations
// ============================================================================
module mul_operand_ctrl #(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int OVF_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         sw,
    input  logic                 btn_load,
    input  logic                 btn_clear,
    output logic [N-1:0]         op_a,
    output logic [N-1:0]         op_b,
    input  logic [N-1:0]         prod,
    input  logic                 ovf,
    output logic [N-1:0]         result,
    output logic                 result_ovf,
    output logic                 done,
    output logic [1:0]           state,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int             CNT_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // Button conditioning: bit 0 = load, bit 1 = clear
    // ------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;

    assign btn_raw = {btn_clear, btn_load};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             deb_q;
        logic             deb_d;
        logic             deb_prev_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // The counter holds how many consecutive earlier cycles the
        // synchronized level has differed from the debounced level; the
        // level flips on the DEB_CYCLES-th such cycle.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = ~deb_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                sync1_q    <= btn_raw[gi];
                sync2_q    <= sync1_q;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                cnt_q      <= cnt_d;
            end
        end

        // One-cycle pulse on a debounced rising edge only
        assign btn_pulse[gi] = deb_q & ~deb_prev_q;
    end

    logic load_pulse;
    logic clear_pulse;

    assign load_pulse  = btn_pulse[0];
    assign clear_pulse = btn_pulse[1];

    // ------------------------------------------------------------------------
    // Operand / result FSM
    // ------------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic [N-1:0]          op_a_q,       op_a_d;
    logic [N-1:0]          op_b_q,       op_b_d;
    logic [N-1:0]          result_q,     result_d;
    logic                  result_ovf_q, result_ovf_d;
    logic                  done_q,       done_d;
    logic [OVF_CNT_W-1:0]  ovf_count_q,  ovf_count_d;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;
        done_d       = done_q;
        ovf_count_d  = ovf_count_q;

        // Clear has priority over everything, including an S_EXEC capture.
        // The overflow counter survives a clear.
        if (clear_pulse) begin
            state_d      = S_A;
            op_a_d       = '0;
            op_b_d       = '0;
            result_d     = '0;
            result_ovf_d = 1'b0;
            done_d       = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (load_pulse) begin
                        op_a_d  = sw;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (load_pulse) begin
                        op_b_d  = sw;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // op_b was registered a cycle ago, so prod/ovf are settled
                    result_d     = prod;
                    result_ovf_d = ovf;
                    done_d       = 1'b1;
                    state_d      = S_SHOW;
                    if (ovf && (ovf_count_q != '1)) begin
                        ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    // result stays on display until the next S_EXEC
                    if (load_pulse) begin
                        op_a_d  = sw;
                        done_d  = 1'b0;
                        state_d = S_B;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_A;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            done_q       <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
            done_q       <= done_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign result     = result_q;
    assign result_ovf = result_ovf_q;
    assign done       = done_q;
    assign state      = state_q;
    assign ovf_count  = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_operand_ctrl
// Purpose  : Self-checking bench for mul_operand_ctrl with N=4, DEB_CYCLES=4,
//            OVF_CNT_W=2. A behavioural model tracks raw button history and
//            operation rules; every cycle all outputs are compared against
//            it, and directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_operand_ctrl;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int OW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  sw = '0;
    logic          btn_load = 1'b0;
    logic          btn_clear = 1'b0;
    logic [N-1:0]  op_a, op_b, prod, result;
    logic          ovf, result_ovf, done;
    logic [1:0]    state;
    logic [OW-1:0] ovf_count;
    logic [2*N-1:0] full;

    // Combinational array multiplier stand-in
    assign full = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
    assign prod = full[N-1:0];
    assign ovf  = |full[2*N-1:N];

    mul_operand_ctrl #(.N(N), .DEB_CYCLES(DEB), .OVF_CNT_W(OW)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
        .op_a(op_a), .op_b(op_b), .prod(prod), .ovf(ovf), .result(result),
        .result_ovf(result_ovf), .done(done), .state(state), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int m_state, m_a, m_b, m_res, m_rovf, m_done, m_cnt;
    bit hist_l[$];
    bit hist_c[$];
    bit lvl_l, lvl_c, rose_l, rose_c;

    // True when every synchronized sample in the window (raw samples 2..DEB+1
    // edges old) disagrees with the current debounced level.
    function automatic bit window_differs(input bit q[$], input bit lvl);
        for (int i = 2; i < DEB + 2; i++) begin
            if (q[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_rovf = 0; m_done = 0; m_cnt = 0;
        hist_l = {}; hist_c = {};
        for (int i = 0; i < DEB + 2; i++) begin
            hist_l.push_back(1'b0);
            hist_c.push_back(1'b0);
        end
        lvl_l = 0; lvl_c = 0; rose_l = 0; rose_c = 0;
    endtask

    task automatic model_step();
        bit lp, cp;
        int prd;
        lp = rose_l;
        cp = rose_c;
        if (cp) begin
            m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_rovf = 0; m_done = 0;
        end else begin
            case (m_state)
                0: if (lp) begin m_a = int'(sw); m_state = 1; end
                1: if (lp) begin m_b = int'(sw); m_state = 2; end
                2: begin
                    prd    = m_a * m_b;
                    m_res  = prd % (1 << N);
                    m_rovf = (prd >= (1 << N)) ? 1 : 0;
                    m_done = 1;
                    if (m_rovf == 1 && m_cnt < (1 << OW) - 1) m_cnt++;
                    m_state = 3;
                end
                default: if (lp) begin m_a = int'(sw); m_done = 0; m_state = 1; end
            endcase
        end
        hist_l.push_front(btn_load);  void'(hist_l.pop_back());
        hist_c.push_front(btn_clear); void'(hist_c.pop_back());
        rose_l = 0;
        if (window_differs(hist_l, lvl_l)) begin lvl_l = ~lvl_l; rose_l = lvl_l; end
        rose_c = 0;
        if (window_differs(hist_c, lvl_c)) begin lvl_c = ~lvl_c; rose_c = lvl_c; end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("op_a",       int'(op_a),       m_a);
            check("op_b",       int'(op_b),       m_b);
            check("result",     int'(result),     m_res);
            check("result_ovf", int'(result_ovf), m_rovf);
            check("done",       int'(done),       m_done);
            check("state",      int'(state),      m_state);
            check("ovf_count",  int'(ovf_count),  m_cnt);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after a rising edge)
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [N-1:0] v, input int hold = 6, input int gap = 10);
        sw = v; btn_load = 1'b1; tick(hold);
        btn_load = 1'b0; tick(gap);
    endtask

    task automatic press_clear(input int hold = 6, input int gap = 10);
        btn_clear = 1'b1; tick(hold);
        btn_clear = 1'b0; tick(gap);
    endtask

    task automatic do_reset();
        rst = 1'b0; tick(3);
        rst = 1'b1; tick(2);
    endtask

    initial begin
        int r;
        tick(3);
        // Reset state
        check("rst_state", int'(state), 0);
        check("rst_done",  int'(done),  0);
        rst = 1'b1; tick(2);

        // Clean presses 3 x 5
        press_load(4'd3);
        check("clean_op_a", int'(op_a), 3);
        press_load(4'd5);
        check("clean_op_b",   int'(op_b),       5);
        check("clean_result", int'(result),     15);
        check("clean_rovf",   int'(result_ovf), 0);
        check("clean_done",   int'(done),       1);
        check("clean_state",  int'(state),      3);
        check("clean_cnt",    int'(ovf_count),  0);

        // Overflow 4 x 4, then 2 x 7 from S_SHOW
        press_load(4'd4);
        press_load(4'd4);
        check("ovf_result", int'(result),     0);
        check("ovf_rovf",   int'(result_ovf), 1);
        check("ovf_cnt",    int'(ovf_count),  1);
        press_load(4'd2);
        check("show_load_done",  int'(done),  0);
        check("show_load_state", int'(state), 1);
        press_load(4'd7);
        check("r14_result", int'(result),     14);
        check("r14_rovf",   int'(result_ovf), 0);
        check("r14_cnt",    int'(ovf_count),  1);

        // Bounce, glitch, then a clean 6-cycle hold
        press_clear();
        sw = 4'd6;
        for (int i = 0; i < 5; i++) begin
            btn_load = 1'b1; tick(2);
            btn_load = 1'b0; tick(2);
        end
        tick(10);
        check("bounce_state", int'(state), 0);
        press_load(4'd6, 3);
        check("glitch_state", int'(state), 0);
        check("glitch_op_a",  int'(op_a),  0);
        press_load(4'd6, 6);
        check("hold_state", int'(state), 1);
        check("hold_op_a",  int'(op_a),  6);

        // Clear mid-operation
        press_clear();
        press_load(4'd9);
        check("a9_op_a", int'(op_a), 9);
        press_clear();
        check("clrB_state", int'(state), 0);
        check("clrB_op_a",  int'(op_a),  0);
        check("clrB_op_b",  int'(op_b),  0);

        // Clear and load in the same cycle: clear wins
        sw = 4'd11; btn_load = 1'b1; btn_clear = 1'b1; tick(6);
        btn_load = 1'b0; btn_clear = 1'b0; tick(10);
        check("both_state", int'(state), 0);
        check("both_op_a",  int'(op_a),  0);

        // Asynchronous reset mid-cycle from S_SHOW with result 15
        press_load(4'd3);
        press_load(4'd5);
        check("pre_rst_result", int'(result), 15);
        #2 rst = 1'b0;
        #1;
        check("arst_op_a",   int'(op_a),       0);
        check("arst_op_b",   int'(op_b),       0);
        check("arst_result", int'(result),     0);
        check("arst_rovf",   int'(result_ovf), 0);
        check("arst_done",   int'(done),       0);
        check("arst_state",  int'(state),      0);
        check("arst_cnt",    int'(ovf_count),  0);
        tick(2);
        rst = 1'b1; tick(2);
        press_load(4'd6);
        check("post_rst_op_a",  int'(op_a),  6);
        check("post_rst_state", int'(state), 1);

        // Saturation of the 2-bit overflow counter
        do_reset();
        for (int k = 0; k < 4; k++) begin
            press_load(4'd15);
            press_load(4'd15);
            check("sat_cnt", int'(ovf_count), (k < 3) ? k + 1 : 3);
        end

        // Randomized phase, checked by the per-cycle model compare
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 11);
            if (r <= 5) begin
                sw = N'($urandom_range(0, 15));
                for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                    btn_load = 1'($urandom_range(0, 1)); tick(1);
                end
                press_load(sw, $urandom_range(3, 9), $urandom_range(3, 12));
            end else if (r == 6) begin
                press_clear($urandom_range(3, 8), $urandom_range(3, 12));
            end else if (r == 7) begin
                btn_load = 1'b1; btn_clear = 1'($urandom_range(0, 1));
                tick($urandom_range(1, 3));
                btn_load = 1'b0; btn_clear = 1'b0; tick($urandom_range(2, 8));
            end else if (r == 8) begin
                sw = N'($urandom_range(0, 15));
                btn_load = 1'b1; btn_clear = 1'b1; tick($urandom_range(4, 7));
                btn_load = 1'b0; btn_clear = 1'b0; tick(10);
            end else if (r == 9) begin
                #($urandom_range(1, 3)) rst = 1'b0;
                tick($urandom_range(1, 3));
                rst = 1'b1; tick(2);
            end else begin
                sw = N'($urandom_range(0, 15));
                tick($urandom_range(1, 10));
            end
        end
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
